// File: rtl/lmac_pkg.sv
// lmac_pkg
// Shared definitions for the LMAC receive path.
//   - Bit positions of the frame markers inside the 40-bit word control.
//   - Idle word constants used when a synthetic terminator word is built.
//   - State encoding of the frame admission controller.
package lmac_pkg;

   localparam int CTRL_PRE_SOF = 32;
   localparam int CTRL_SOF     = 33;
   localparam int CTRL_PRE_EOF = 34;
   localparam int CTRL_EOF     = 35;
   localparam int CTRL_ERR     = 36;

   // An idle word carries 0x07 in every byte and flags every byte as control
   localparam logic [255:0] IDLE_DATA = {32{8'h07}};
   localparam logic [31:0]  IDLE_CTRL = 32'hffff_ffff;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS,
      ST_DISCARD,
      ST_TERM
   } admit_state_e;

endpackage

// File: rtl/rx_frame_cnt.sv
// rx_frame_cnt
// Three wrapping per-frame statistics counters, each advanced by one-cycle
// increment strobes.
// Ports:
//   clk_i, reset_i            clock and asynchronous active-high reset
//   incOk_i, incDrop_i,       increment strobes, one count per high cycle
//   incTrunc_i
//   framesOk_o, framesDrop_o, counter values, wrap modulo 2^CNT_W
//   framesTrunc_o
module rx_frame_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             incOk_i,
   input  logic             incDrop_i,
   input  logic             incTrunc_i,
   output logic [CNT_W-1:0] framesOk_o,
   output logic [CNT_W-1:0] framesDrop_o,
   output logic [CNT_W-1:0] framesTrunc_o
);

   // Counters simply roll over at the top of their range; software reads
   // differences, so wrapping is harmless.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         framesOk_o    <= '0;
         framesDrop_o  <= '0;
         framesTrunc_o <= '0;
      end else begin
         if (incOk_i)    framesOk_o    <= framesOk_o    + CNT_W'(1);
         if (incDrop_i)  framesDrop_o  <= framesDrop_o  + CNT_W'(1);
         if (incTrunc_i) framesTrunc_o <= framesTrunc_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rx_frame_admit.sv
// rx_frame_admit
// Frame-level admission controller between the rx_100G datapath and the BR
// FIFO. Space is checked once per frame at its sof word, so every frame is
// written whole, dropped whole, or cut short with eof+err so the FIFO never
// holds an unterminated frame.
// Ports:
//   x_clk, reset        datapath clock, asynchronous active-high reset
//   linkup              link status from the RX datapath
//   we_in/data_in/      input word valid, 256-bit data, 40-bit control
//   ctrl_in             (ctrl_in[33]=sof, ctrl_in[35]=eof)
//   fifo_free           free words in the BR FIFO
//   fifo_we/fifo_data/  registered write port toward the BR FIFO,
//   fifo_ctrl           fifo_ctrl[36] marks an errored (cut) frame
//   frames_ok/_drop/    wrapping statistics counters
//   _trunc
//   ovf_err             sticky overflow flag, cleared only by reset
module rx_frame_admit
   import lmac_pkg::*;
#(
   parameter int MAX_WORDS = 48,
   parameter int FREE_W    = 10,
   parameter int CNT_W     = 16
) (
   input  logic              x_clk,
   input  logic              reset,
   input  logic              linkup,
   input  logic              we_in,
   input  logic [255:0]      data_in,
   input  logic [39:0]       ctrl_in,
   input  logic [FREE_W-1:0] fifo_free,
   output logic [255:0]      fifo_data,
   output logic [39:0]       fifo_ctrl,
   output logic              fifo_we,
   output logic [CNT_W-1:0]  frames_ok,
   output logic [CNT_W-1:0]  frames_drop,
   output logic [CNT_W-1:0]  frames_trunc,
   output logic              ovf_err
);

   localparam int WCNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WORDS - 1);
   localparam logic [FREE_W-1:0] FREE_MIN  = FREE_W'(MAX_WORDS);

   admit_state_e      state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              we_q, we_d;
   logic [255:0]      data_q, data_d;
   logic [39:0]       ctrl_q, ctrl_d;
   logic              ovf_q, ovf_d;
   logic              incOk, incDrop, incTrunc;
   logic              sof, eof, admit, startFrame, singleWord;
   logic [39:0]       passCtrl;
   logic              unusedCtrl;

   assign sof      = ctrl_in[CTRL_SOF];
   assign eof      = ctrl_in[CTRL_EOF];
   assign admit    = linkup && (fifo_free >= FREE_MIN);
   assign passCtrl = {4'b0000, ctrl_in[35:0]};

   // The top nibble of the input control carries nothing for this block
   assign unusedCtrl = ^ctrl_in[39:36];

   // Next-state logic. The per-state case decides what the word means for the
   // frame already open; an sof that must open a new frame only raises
   // startFrame, and the shared admission block below handles it the same way
   // from IDLE, from an eof+sof word in PASS and from an eof+sof word in
   // DISCARD. Within PASS the checks run overflow, eof, truncation, then
   // link loss, which is the required priority order.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      we_d       = 1'b0;
      data_d     = data_q;
      ctrl_d     = ctrl_q;
      ovf_d      = ovf_q;
      incOk      = 1'b0;
      incDrop    = 1'b0;
      incTrunc   = 1'b0;
      startFrame = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (we_in && sof) startFrame = 1'b1;
         end
         ST_PASS: begin
            if (we_in) begin
               if (fifo_free == '0) begin
                  ovf_d   = 1'b1;
                  state_d = ST_DISCARD;
               end else begin
                  we_d   = 1'b1;
                  data_d = data_in;
                  ctrl_d = passCtrl;
                  if (eof) begin
                     incOk   = 1'b1;
                     state_d = ST_IDLE;
                     wcnt_d  = '0;
                     if (sof) startFrame = 1'b1;
                  end else if (wcnt_q == WCNT_LAST) begin
                     ctrl_d[CTRL_EOF] = 1'b1;
                     ctrl_d[CTRL_ERR] = 1'b1;
                     incTrunc         = 1'b1;
                     state_d          = ST_DISCARD;
                     wcnt_d           = '0;
                  end else begin
                     wcnt_d = wcnt_q + WCNT_W'(1);
                  end
               end
            end else if (!linkup) begin
               state_d = ST_TERM;
            end
         end
         ST_DISCARD: begin
            if (we_in && eof) begin
               state_d = ST_IDLE;
               if (sof) startFrame = 1'b1;
            end
         end
         ST_TERM: begin
            we_d     = 1'b1;
            data_d   = IDLE_DATA;
            ctrl_d   = {3'b000, 1'b1, 1'b1, 3'b000, IDLE_CTRL};
            incTrunc = 1'b1;
            wcnt_d   = '0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outside IDLE the eof bit of a shared word closes the previous frame,
      // so only from IDLE does eof make the new frame a single-word frame.
      singleWord = eof && (state_q == ST_IDLE);
      if (startFrame) begin
         if (admit) begin
            we_d   = 1'b1;
            data_d = data_in;
            ctrl_d = passCtrl;
            wcnt_d = WCNT_W'(1);
            if (singleWord) begin
               incOk   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_PASS;
            end
         end else begin
            incDrop = 1'b1;
            state_d = singleWord ? ST_IDLE : ST_DISCARD;
         end
      end
   end

   // All controller state and the FIFO write port are registered here, so
   // every output follows its input word by exactly one cycle and reset
   // abandons any open frame at once.
   always_ff @(posedge x_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         ovf_q   <= ovf_d;
      end
   end

   assign fifo_we   = we_q;
   assign fifo_data = data_q;
   assign fifo_ctrl = ctrl_q;
   assign ovf_err   = ovf_q;

   // Counter strobes come from the same next-state logic as the write, so the
   // counters move on the same edge that raises fifo_we.
   rx_frame_cnt #(
      .CNT_W(CNT_W)
   ) uCnt (
      .clk_i        (x_clk),
      .reset_i      (reset),
      .incOk_i      (incOk),
      .incDrop_i    (incDrop),
      .incTrunc_i   (incTrunc),
      .framesOk_o   (frames_ok),
      .framesDrop_o (frames_drop),
      .framesTrunc_o(frames_trunc)
   );

endmodule

// File: tb/tb_rx_frame_admit.sv
// tb_rx_frame_admit
// Directed bench for rx_frame_admit: one task per scenario, each with its own
// hand-computed expectations.
module tb_rx_frame_admit;

   localparam logic [39:0] C_SOF  = 40'h02_0000_0000;
   localparam logic [39:0] C_EOF  = 40'h08_0000_0000;
   localparam logic [39:0] C_TERM = 40'h18_ffff_ffff;

   logic         x_clk;
   logic         reset;
   logic         linkup;
   logic         we_in;
   logic [255:0] data_in;
   logic [39:0]  ctrl_in;
   logic [9:0]   fifo_free;
   logic [255:0] fifo_data;
   logic [39:0]  fifo_ctrl;
   logic         fifo_we;
   logic [15:0]  frames_ok;
   logic [15:0]  frames_drop;
   logic [15:0]  frames_trunc;
   logic         ovf_err;

   int cmpCount;
   int failCount;
   int wrCount;
   int base;

   rx_frame_admit #(
      .MAX_WORDS(48),
      .FREE_W   (10),
      .CNT_W    (16)
   ) dut (
      .x_clk       (x_clk),
      .reset       (reset),
      .linkup      (linkup),
      .we_in       (we_in),
      .data_in     (data_in),
      .ctrl_in     (ctrl_in),
      .fifo_free   (fifo_free),
      .fifo_data   (fifo_data),
      .fifo_ctrl   (fifo_ctrl),
      .fifo_we     (fifo_we),
      .frames_ok   (frames_ok),
      .frames_drop (frames_drop),
      .frames_trunc(frames_trunc),
      .ovf_err     (ovf_err)
   );

   // 10 ns datapath clock
   initial begin
      x_clk = 1'b0;
      forever #5 x_clk = ~x_clk;
   end

   // Count FIFO writes on the falling edge, away from the active edge
   always @(negedge x_clk) begin
      if (fifo_we === 1'b1) wrCount++;
   end

   function automatic logic [255:0] pat(input logic [7:0] b);
      return {32{b}};
   endfunction

   // Present one valid word for one cycle; returns 1 ns after the edge that
   // captured it, when the matching registered outputs are visible.
   task automatic sendWord(input logic [255:0] d, input logic [39:0] c);
      we_in   = 1'b1;
      data_in = d;
      ctrl_in = c;
      @(posedge x_clk);
      #1;
      we_in   = 1'b0;
      ctrl_in = '0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge x_clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; linkup = 1'b1; we_in = 1'b0; data_in = '0; ctrl_in = '0; fifo_free = 10'd100;
      #12;
      cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL reset_we: got %b expected 0", fifo_we); end
      cmpCount++; if (fifo_data !== '0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 0", fifo_data); end
      cmpCount++; if (fifo_ctrl !== '0) begin failCount++; $display("[TB] FAIL reset_ctrl: got %h expected 0", fifo_ctrl); end
      cmpCount++; if (frames_ok !== 16'd0 || frames_drop !== 16'd0 || frames_trunc !== 16'd0) begin
         failCount++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", frames_ok, frames_drop, frames_trunc);
      end
      cmpCount++; if (ovf_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_err); end
      @(posedge x_clk);
      #1 reset = 1'b0;
      idleCycles(1);
   endtask

   task automatic test_basic;
      base = wrCount;
      fifo_free = 10'd100;
      // Top nibble of the input control must be cleared on the way out
      sendWord(pat(8'h11), 40'hF2_0000_0001);
      cmpCount++; if (fifo_we !== 1'b1) begin failCount++; $display("[TB] FAIL basic_first_we: got %b expected 1", fifo_we); end
      cmpCount++; if (fifo_data !== pat(8'h11)) begin failCount++; $display("[TB] FAIL basic_first_data: got %h expected %h", fifo_data, pat(8'h11)); end
      cmpCount++; if (fifo_ctrl !== 40'h02_0000_0001) begin failCount++; $display("[TB] FAIL basic_first_ctrl: got %h expected 0200000001", fifo_ctrl); end
      sendWord(pat(8'h12), 40'h00_0000_0000);
      sendWord(pat(8'h13), C_EOF | 40'h0f);
      cmpCount++; if (fifo_ctrl !== 40'h08_0000_000f) begin failCount++; $display("[TB] FAIL basic_eof_ctrl: got %h expected 080000000f", fifo_ctrl); end
      cmpCount++; if (frames_ok !== 16'd1) begin failCount++; $display("[TB] FAIL basic_frames_ok: got %0d expected 1", frames_ok); end
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 3) begin failCount++; $display("[TB] FAIL basic_writes: got %0d expected 3", wrCount - base); end
      cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL basic_idle_we: got %b expected 0", fifo_we); end
   endtask

   task automatic test_drop;
      base = wrCount;
      fifo_free = 10'd47;
      sendWord(pat(8'h21), C_SOF);
      cmpCount++; if (frames_drop !== 16'd1) begin failCount++; $display("[TB] FAIL drop_count: got %0d expected 1", frames_drop); end
      sendWord(pat(8'h22), '0);
      fifo_free = 10'd100;
      sendWord(pat(8'h23), '0);
      sendWord(pat(8'h24), C_EOF);
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 0) begin failCount++; $display("[TB] FAIL drop_writes: got %0d expected 0", wrCount - base); end
      fifo_free = 10'd48;
      sendWord(pat(8'h25), C_SOF);
      sendWord(pat(8'h26), C_EOF);
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 2) begin failCount++; $display("[TB] FAIL drop_next_writes: got %0d expected 2", wrCount - base); end
      cmpCount++; if (frames_ok !== 16'd2) begin failCount++; $display("[TB] FAIL drop_next_ok: got %0d expected 2", frames_ok); end
   endtask

   task automatic test_trunc;
      base = wrCount;
      fifo_free = 10'd100;
      for (int i = 1; i <= 60; i++) begin
         sendWord(pat(8'(i)), (i == 1) ? C_SOF : ((i == 60) ? C_EOF : 40'h0));
         if (i == 48) begin
            cmpCount++; if (fifo_we !== 1'b1 || fifo_ctrl !== 40'h18_0000_0000) begin
               failCount++; $display("[TB] FAIL trunc_last_word: got we=%b ctrl=%h expected we=1 ctrl=1800000000", fifo_we, fifo_ctrl);
            end
            cmpCount++; if (frames_trunc !== 16'd1) begin failCount++; $display("[TB] FAIL trunc_count: got %0d expected 1", frames_trunc); end
         end
         if (i == 49) begin
            cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL trunc_word49_we: got %b expected 0", fifo_we); end
         end
      end
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 48) begin failCount++; $display("[TB] FAIL trunc_writes: got %0d expected 48", wrCount - base); end
      sendWord(pat(8'h3a), C_SOF | C_EOF);
      cmpCount++; if (fifo_we !== 1'b1 || frames_ok !== 16'd3) begin
         failCount++; $display("[TB] FAIL trunc_next_sof: got we=%b ok=%0d expected we=1 ok=3", fifo_we, frames_ok);
      end
      idleCycles(1);
   endtask

   task automatic test_linkdrop;
      base = wrCount;
      fifo_free = 10'd100;
      for (int i = 1; i <= 5; i++) sendWord(pat(8'(8'h40 + i)), (i == 1) ? C_SOF : 40'h0);
      linkup = 1'b0;
      idleCycles(1);
      cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL link_gap_we: got %b expected 0", fifo_we); end
      idleCycles(1);
      cmpCount++; if (fifo_we !== 1'b1 || fifo_data !== {32{8'h07}}) begin
         failCount++; $display("[TB] FAIL link_term_data: got we=%b data=%h expected we=1 data=07..07", fifo_we, fifo_data);
      end
      cmpCount++; if (fifo_ctrl !== C_TERM) begin failCount++; $display("[TB] FAIL link_term_ctrl: got %h expected %h", fifo_ctrl, C_TERM); end
      cmpCount++; if (frames_trunc !== 16'd2) begin failCount++; $display("[TB] FAIL link_trunc: got %0d expected 2", frames_trunc); end
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 6) begin failCount++; $display("[TB] FAIL link_writes: got %0d expected 6", wrCount - base); end
      linkup = 1'b1;
      // Back in IDLE a non-sof word must not be written
      sendWord(pat(8'h4f), '0);
      cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL link_idle_state: got we=%b expected 0", fifo_we); end
      idleCycles(1);
   endtask

   task automatic test_overflow;
      base = wrCount;
      fifo_free = 10'd100;
      sendWord(pat(8'h51), C_SOF);
      sendWord(pat(8'h52), '0);
      fifo_free = 10'd0;
      sendWord(pat(8'h53), '0);
      cmpCount++; if (fifo_we !== 1'b0 || ovf_err !== 1'b1) begin
         failCount++; $display("[TB] FAIL ovf_word3: got we=%b ovf=%b expected we=0 ovf=1", fifo_we, ovf_err);
      end
      fifo_free = 10'd100;
      sendWord(pat(8'h54), '0);
      sendWord(pat(8'h55), C_EOF);
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 2) begin failCount++; $display("[TB] FAIL ovf_writes: got %0d expected 2", wrCount - base); end
      idleCycles(5);
      sendWord(pat(8'h56), C_SOF | C_EOF);
      cmpCount++; if (ovf_err !== 1'b1 || frames_ok !== 16'd4) begin
         failCount++; $display("[TB] FAIL ovf_sticky: got ovf=%b ok=%0d expected ovf=1 ok=4", ovf_err, frames_ok);
      end
      idleCycles(1);
   endtask

   task automatic test_back_to_back;
      reset = 1'b1;
      #2;
      cmpCount++; if (ovf_err !== 1'b0 || frames_ok !== 16'd0) begin
         failCount++; $display("[TB] FAIL b2b_reset_clear: got ovf=%b ok=%0d expected 0/0", ovf_err, frames_ok);
      end
      @(posedge x_clk);
      #1 reset = 1'b0;
      idleCycles(1);
      base = wrCount;
      fifo_free = 10'd100;
      sendWord(pat(8'h61), C_SOF);
      sendWord(pat(8'h62), '0);
      sendWord(pat(8'h63), C_SOF | C_EOF);
      cmpCount++; if (fifo_we !== 1'b1 || frames_ok !== 16'd1) begin
         failCount++; $display("[TB] FAIL b2b_shared: got we=%b ok=%0d expected we=1 ok=1", fifo_we, frames_ok);
      end
      sendWord(pat(8'h64), '0);
      sendWord(pat(8'h65), C_EOF);
      cmpCount++; if (frames_ok !== 16'd2) begin failCount++; $display("[TB] FAIL b2b_ok: got %0d expected 2", frames_ok); end
      idleCycles(1);
      cmpCount++; if (wrCount - base !== 5) begin failCount++; $display("[TB] FAIL b2b_writes: got %0d expected 5", wrCount - base); end

      // Reset in the middle of a frame, between clock edges
      base = wrCount;
      sendWord(pat(8'h71), C_SOF);
      sendWord(pat(8'h72), '0);
      #2 reset = 1'b1;
      #1;
      cmpCount++; if (fifo_we !== 1'b0 || fifo_data !== '0 || fifo_ctrl !== '0) begin
         failCount++; $display("[TB] FAIL b2b_async_reset: got we=%b data=%h ctrl=%h expected all 0", fifo_we, fifo_data, fifo_ctrl);
      end
      cmpCount++; if (frames_ok !== 16'd0) begin failCount++; $display("[TB] FAIL b2b_reset_ok: got %0d expected 0", frames_ok); end
      @(posedge x_clk);
      #1 reset = 1'b0;
      sendWord(pat(8'h73), '0);
      cmpCount++; if (fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_abandon_we: got %b expected 0", fifo_we); end
      idleCycles(2);
      cmpCount++; if (wrCount - base !== 1) begin failCount++; $display("[TB] FAIL b2b_abandon_writes: got %0d expected 1", wrCount - base); end
   endtask

   initial begin
      cmpCount  = 0;
      failCount = 0;
      wrCount   = 0;
      test_reset;
      test_basic;
      test_drop;
      test_trunc;
      test_linkdrop;
      test_overflow;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
